// File: rtl/pkt_data_cache.sv
// pkt_data_cache
//    Packet buffer behind the parser's pass-through path. Incoming 134-bit words
//    are written into a local RAM as they arrive. The end-of-packet verdict either
//    commits the packet (commit_ptr advances past the tail) or rolls it back
//    (wr_ptr returns to commit_ptr). Committed packets are replayed whole, one word
//    per cycle, with the verdict strobe on the tail word.
//
//    Ports
//       clk, rst          clock, asynchronous active-high reset
//       in_data_wr        input word strobe
//       in_data[133:0]    [133:132] type (01 head, 11 middle, 10 tail), [127:0] payload
//       in_valid_wr       verdict strobe, arrives with the tail word
//       in_valid          verdict: 1 keep, 0 discard
//       out_alf           almost-full to upstream (free words < ALF_MARGIN)
//       out_data_wr       output word strobe
//       out_data[133:0]   output word
//       out_valid_wr      verdict strobe with the output tail word
//       out_valid         always 1 alongside out_valid_wr
//       in_alf            downstream almost-full, sampled only between packets
//       stat_commit_cnt   committed packets
//       stat_drop_cnt     rolled-back and head-aborted packets
//
//    Optional feature: define PKT_CACHE_STAT_EN to build the two 32-bit wrapping
//    statistics counters. Without it both stat ports are tied to zero.
//
//    Read FSM
//       state   | meaning
//       S_IDLE  | waiting for a committed packet and in_alf low
//       S_SEND  | one RAM read per cycle until the tail word has been read
//       S_DRAIN | tail word leaves the output register, packet count drops

module pkt_data_cache #(
   parameter int DEPTH_LOG2    = 8,
   parameter int ALF_MARGIN    = 32,
   parameter int MAX_PKTS_LOG2 = 6
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_data_wr,
   input  logic [133:0] in_data,
   input  logic         in_valid_wr,
   input  logic         in_valid,
   output logic         out_alf,
   output logic         out_data_wr,
   output logic [133:0] out_data,
   output logic         out_valid_wr,
   output logic         out_valid,
   input  logic         in_alf,
   output logic [31:0]  stat_commit_cnt,
   output logic [31:0]  stat_drop_cnt
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int PW    = DEPTH_LOG2 + 1;

   localparam logic [1:0] TYPE_HEAD = 2'b01;
   localparam logic [1:0] TYPE_TAIL = 2'b10;

   typedef logic [PW-1:0] ptr_t;
   typedef enum logic [1:0] {S_IDLE, S_SEND, S_DRAIN} rd_state_t;

   logic [133:0] mem [DEPTH];
   logic [133:0] mem_rdata_q;

   ptr_t wr_ptr_q, wr_ptr_d;
   ptr_t commit_ptr_q, commit_ptr_d;
   ptr_t rd_ptr_q, rd_ptr_d;
   logic ovf_q, ovf_d;
   logic open_q, open_d;
   logic [MAX_PKTS_LOG2-1:0] pkt_cnt_q, pkt_cnt_d;
   rd_state_t state_q, state_d;
   logic rd_vld_q, rd_vld_d;
   logic rd_tail_q, rd_tail_d;
   logic out_alf_q, out_alf_d;
   logic out_data_wr_q, out_data_wr_d;
   logic out_valid_wr_q, out_valid_wr_d;
   logic [133:0] out_data_q, out_data_d;

   // write-side decode
   logic head_abort, full, wr_en, ovf_hit, ovf_cur, commit, rollback;
   ptr_t wr_base, wr_next, used_base, used_q, free_q;

   // read-side decode
   logic [DEPTH_LOG2-1:0] rd_idx;
   logic rd_en, rd_word_tail, pkt_done;

   always_comb begin
      // A head while a packet is open throws the partial packet away and
      // restarts writing at the last committed position.
      head_abort = in_data_wr && (in_data[133:132] == TYPE_HEAD) && open_q;
      wr_base    = head_abort ? commit_ptr_q : wr_ptr_q;
      used_base  = wr_base - rd_ptr_q;
      full       = (used_base == ptr_t'(DEPTH));
      wr_en      = in_data_wr && !full;
      ovf_hit    = in_data_wr && full;
      wr_next    = wr_en ? (wr_base + ptr_t'(1)) : wr_base;
      // An overflow on the tail word itself also spoils the packet.
      ovf_cur    = (ovf_q && !head_abort) || ovf_hit;
      commit     = in_valid_wr && in_valid && !ovf_cur && !(&pkt_cnt_q);
      rollback   = in_valid_wr && !commit;

      wr_ptr_d     = wr_next;
      commit_ptr_d = commit_ptr_q;
      ovf_d        = ovf_cur;
      open_d       = open_q || in_data_wr;
      if (commit) begin
         commit_ptr_d = wr_next;
         ovf_d        = 1'b0;
         open_d       = 1'b0;
      end else if (rollback) begin
         wr_ptr_d = commit_ptr_q;
         ovf_d    = 1'b0;
         open_d   = 1'b0;
      end

      used_q    = wr_ptr_q - rd_ptr_q;
      free_q    = ptr_t'(DEPTH) - used_q;
      out_alf_d = (free_q < ptr_t'(ALF_MARGIN));
   end

   always_comb begin
      rd_idx       = rd_ptr_q[DEPTH_LOG2-1:0];
      rd_word_tail = (mem[rd_idx][133:132] == TYPE_TAIL);
      // Never read past the committed region; a missing tail stalls rather
      // than replaying uncommitted words.
      rd_en        = (state_q == S_SEND) && (rd_ptr_q != commit_ptr_q);
      pkt_done     = (state_q == S_DRAIN);

      state_d = state_q;
      case (state_q)
         S_IDLE:  if ((pkt_cnt_q != '0) && !in_alf) state_d = S_SEND;
         S_SEND:  if (rd_en && rd_word_tail) state_d = S_DRAIN;
         S_DRAIN: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      rd_ptr_d  = rd_en ? (rd_ptr_q + ptr_t'(1)) : rd_ptr_q;
      rd_vld_d  = rd_en;
      rd_tail_d = rd_en && rd_word_tail;

      out_data_wr_d  = rd_vld_q;
      out_valid_wr_d = rd_vld_q && rd_tail_q;
      out_data_d     = rd_vld_q ? mem_rdata_q : out_data_q;

      pkt_cnt_d = pkt_cnt_q;
      if (commit && !pkt_done) begin
         pkt_cnt_d = pkt_cnt_q + 1'b1;
      end else if (!commit && pkt_done) begin
         pkt_cnt_d = pkt_cnt_q - 1'b1;
      end
   end

   // RAM and its registered read port carry no reset.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_base[DEPTH_LOG2-1:0]] <= in_data;
      end
      if (rd_en) begin
         mem_rdata_q <= mem[rd_idx];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q       <= '0;
         commit_ptr_q   <= '0;
         rd_ptr_q       <= '0;
         ovf_q          <= 1'b0;
         open_q         <= 1'b0;
         pkt_cnt_q      <= '0;
         state_q        <= S_IDLE;
         rd_vld_q       <= 1'b0;
         rd_tail_q      <= 1'b0;
         out_alf_q      <= 1'b0;
         out_data_wr_q  <= 1'b0;
         out_valid_wr_q <= 1'b0;
         out_data_q     <= '0;
      end else begin
         wr_ptr_q       <= wr_ptr_d;
         commit_ptr_q   <= commit_ptr_d;
         rd_ptr_q       <= rd_ptr_d;
         ovf_q          <= ovf_d;
         open_q         <= open_d;
         pkt_cnt_q      <= pkt_cnt_d;
         state_q        <= state_d;
         rd_vld_q       <= rd_vld_d;
         rd_tail_q      <= rd_tail_d;
         out_alf_q      <= out_alf_d;
         out_data_wr_q  <= out_data_wr_d;
         out_valid_wr_q <= out_valid_wr_d;
         out_data_q     <= out_data_d;
      end
   end

   assign out_alf      = out_alf_q;
   assign out_data_wr  = out_data_wr_q;
   assign out_data     = out_data_q;
   assign out_valid_wr = out_valid_wr_q;
   assign out_valid    = out_valid_wr_q;

`ifdef PKT_CACHE_STAT_EN
   logic [31:0] stat_commit_q, stat_commit_d;
   logic [31:0] stat_drop_q, stat_drop_d;

   always_comb begin
      stat_commit_d = stat_commit_q + {31'd0, commit};
      stat_drop_d   = stat_drop_q + {31'd0, rollback} + {31'd0, head_abort};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_commit_q <= '0;
         stat_drop_q   <= '0;
      end else begin
         stat_commit_q <= stat_commit_d;
         stat_drop_q   <= stat_drop_d;
      end
   end

   assign stat_commit_cnt = stat_commit_q;
   assign stat_drop_cnt   = stat_drop_q;
`else
   assign stat_commit_cnt = 32'd0;
   assign stat_drop_cnt   = 32'd0;
`endif

endmodule

// File: tb/tb_pkt_data_cache.sv
module tb_pkt_data_cache;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_data_wr;
   logic [133:0] in_data;
   logic         in_valid_wr;
   logic         in_valid;
   logic         out_alf;
   logic         out_data_wr;
   logic [133:0] out_data;
   logic         out_valid_wr;
   logic         out_valid;
   logic         in_alf;
   logic [31:0]  stat_commit_cnt;
   logic [31:0]  stat_drop_cnt;

`ifdef PKT_CACHE_STAT_EN
   localparam bit STAT_EN = 1'b1;
`else
   localparam bit STAT_EN = 1'b0;
`endif

   int checks = 0;
   int errors = 0;

   pkt_data_cache dut (
      .clk(clk), .rst(rst),
      .in_data_wr(in_data_wr), .in_data(in_data),
      .in_valid_wr(in_valid_wr), .in_valid(in_valid),
      .out_alf(out_alf),
      .out_data_wr(out_data_wr), .out_data(out_data),
      .out_valid_wr(out_valid_wr), .out_valid(out_valid),
      .in_alf(in_alf),
      .stat_commit_cnt(stat_commit_cnt), .stat_drop_cnt(stat_drop_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic        d_wr;
      logic [1:0]  d_typ;
      logic [15:0] d_tag;
      logic        v_wr;
      logic        vld;
      logic        alf;
      logic        e_wr;
      logic        e_vw;
      logic [1:0]  e_typ;
      logic [15:0] e_tag;
      int          e_commit;
      int          e_drop;
   } vec_t;

   vec_t vecs[$];

   function automatic logic [133:0] word(input logic [1:0] typ, input logic [15:0] tag);
      return {typ, 4'h0, {8{tag}}};
   endfunction

   function automatic vec_t mkv(input logic d_wr, input logic [1:0] d_typ, input logic [15:0] d_tag,
                                input logic v_wr, input logic vld, input logic alf,
                                input logic e_wr, input logic e_vw, input logic [1:0] e_typ,
                                input logic [15:0] e_tag, input int e_commit, input int e_drop);
      vec_t v;
      v.d_wr = d_wr; v.d_typ = d_typ; v.d_tag = d_tag; v.v_wr = v_wr; v.vld = vld; v.alf = alf;
      v.e_wr = e_wr; v.e_vw = e_vw; v.e_typ = e_typ; v.e_tag = e_tag;
      v.e_commit = e_commit; v.e_drop = e_drop;
      return v;
   endfunction

   task automatic chk(input string name, input logic [133:0] act, input logic [133:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic cyc(input logic dwr, input logic [1:0] typ, input logic [15:0] tag,
                      input logic vwr, input logic vld);
      in_data_wr  = dwr;
      in_data     = dwr ? word(typ, tag) : '0;
      in_valid_wr = vwr;
      in_valid    = vld;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_stats(input string nm, input int c, input int d);
      chk({nm, " stat_commit"}, stat_commit_cnt, STAT_EN ? 32'(c) : 32'd0);
      chk({nm, " stat_drop"}, stat_drop_cnt, STAT_EN ? 32'(d) : 32'd0);
   endtask

   // Waits for one packet of n words tagged base+i; first word expected on the
   // third edge after the commit edge.
   task automatic expect_pkt(input string nm, input int n, input logic [15:0] base);
      int got = 0;
      int first = -1;
      logic [1:0] et;
      for (int k = 1; k <= 40 && got < n; k++) begin
         cyc(1'b0, 2'b00, 16'h0, 1'b0, 1'b0);
         if (out_data_wr) begin
            if (first < 0) first = k;
            et = (got == 0) ? 2'b01 : ((got == n - 1) ? 2'b10 : 2'b11);
            chk($sformatf("%s word%0d data", nm, got), out_data, word(et, base + 16'(got)));
            chk($sformatf("%s word%0d valid_wr", nm, got), out_valid_wr, (got == n - 1));
            got++;
         end
      end
      chk({nm, " word count"}, got, n);
      chk({nm, " latency"}, first, 3);
   endtask

   initial begin
      int spur;
      int cnt;
      int alf_cnt;
      bit fell;
      bit alf_seen;
      logic [1:0] et;

      rst = 1'b1; in_alf = 1'b0;
      in_data_wr = 1'b0; in_data = '0; in_valid_wr = 1'b0; in_valid = 1'b0;

      // d_wr typ tag v_wr vld alf | e_wr e_vw e_typ e_tag commit drop
      vecs.push_back(mkv(1, 2'b01, 16'hA000, 0, 0, 0, 0, 0, 2'b00, 16'h0, 0, 0));
      vecs.push_back(mkv(1, 2'b11, 16'hA001, 0, 0, 0, 0, 0, 2'b00, 16'h0, 0, 0));
      vecs.push_back(mkv(1, 2'b11, 16'hA002, 0, 0, 0, 0, 0, 2'b00, 16'h0, 0, 0));
      vecs.push_back(mkv(1, 2'b10, 16'hA003, 1, 1, 0, 0, 0, 2'b00, 16'h0, 1, 0));
      vecs.push_back(mkv(0, 2'b00, 16'h0,    0, 0, 0, 0, 0, 2'b00, 16'h0, 1, 0));
      vecs.push_back(mkv(0, 2'b00, 16'h0,    0, 0, 0, 0, 0, 2'b00, 16'h0, 1, 0));
      vecs.push_back(mkv(0, 2'b00, 16'h0,    0, 0, 0, 1, 0, 2'b01, 16'hA000, 1, 0));
      vecs.push_back(mkv(0, 2'b00, 16'h0,    0, 0, 0, 1, 0, 2'b11, 16'hA001, 1, 0));
      vecs.push_back(mkv(0, 2'b00, 16'h0,    0, 0, 0, 1, 0, 2'b11, 16'hA002, 1, 0));
      vecs.push_back(mkv(0, 2'b00, 16'h0,    0, 0, 0, 1, 1, 2'b10, 16'hA003, 1, 0));
      vecs.push_back(mkv(0, 2'b00, 16'h0,    0, 0, 0, 0, 0, 2'b00, 16'h0, 1, 0));
      // discarded packet, then a good one
      vecs.push_back(mkv(1, 2'b01, 16'hB000, 0, 0, 0, 0, 0, 2'b00, 16'h0, 1, 0));
      vecs.push_back(mkv(1, 2'b11, 16'hB001, 0, 0, 0, 0, 0, 2'b00, 16'h0, 1, 0));
      vecs.push_back(mkv(1, 2'b10, 16'hB002, 1, 0, 0, 0, 0, 2'b00, 16'h0, 1, 1));
      vecs.push_back(mkv(1, 2'b01, 16'hC000, 0, 0, 0, 0, 0, 2'b00, 16'h0, 1, 1));
      vecs.push_back(mkv(1, 2'b10, 16'hC001, 1, 1, 0, 0, 0, 2'b00, 16'h0, 2, 1));
      vecs.push_back(mkv(0, 2'b00, 16'h0,    0, 0, 0, 0, 0, 2'b00, 16'h0, 2, 1));
      vecs.push_back(mkv(0, 2'b00, 16'h0,    0, 0, 0, 0, 0, 2'b00, 16'h0, 2, 1));
      vecs.push_back(mkv(0, 2'b00, 16'h0,    0, 0, 0, 1, 0, 2'b01, 16'hC000, 2, 1));
      vecs.push_back(mkv(0, 2'b00, 16'h0,    0, 0, 0, 1, 1, 2'b10, 16'hC001, 2, 1));
      vecs.push_back(mkv(0, 2'b00, 16'h0,    0, 0, 0, 0, 0, 2'b00, 16'h0, 2, 1));
      // head abort
      vecs.push_back(mkv(1, 2'b01, 16'hD000, 0, 0, 0, 0, 0, 2'b00, 16'h0, 2, 1));
      vecs.push_back(mkv(1, 2'b11, 16'hD001, 0, 0, 0, 0, 0, 2'b00, 16'h0, 2, 1));
      vecs.push_back(mkv(1, 2'b01, 16'hF000, 0, 0, 0, 0, 0, 2'b00, 16'h0, 2, 2));
      vecs.push_back(mkv(1, 2'b11, 16'hF001, 0, 0, 0, 0, 0, 2'b00, 16'h0, 2, 2));
      vecs.push_back(mkv(1, 2'b10, 16'hF002, 1, 1, 0, 0, 0, 2'b00, 16'h0, 3, 2));
      vecs.push_back(mkv(0, 2'b00, 16'h0,    0, 0, 0, 0, 0, 2'b00, 16'h0, 3, 2));
      vecs.push_back(mkv(0, 2'b00, 16'h0,    0, 0, 0, 0, 0, 2'b00, 16'h0, 3, 2));
      vecs.push_back(mkv(0, 2'b00, 16'h0,    0, 0, 0, 1, 0, 2'b01, 16'hF000, 3, 2));
      vecs.push_back(mkv(0, 2'b00, 16'h0,    0, 0, 0, 1, 0, 2'b11, 16'hF001, 3, 2));
      vecs.push_back(mkv(0, 2'b00, 16'h0,    0, 0, 0, 1, 1, 2'b10, 16'hF002, 3, 2));
      vecs.push_back(mkv(0, 2'b00, 16'h0,    0, 0, 0, 0, 0, 2'b00, 16'h0, 3, 2));
      // two packets held back by in_alf, then released
      vecs.push_back(mkv(1, 2'b01, 16'h6000, 0, 0, 1, 0, 0, 2'b00, 16'h0, 3, 2));
      vecs.push_back(mkv(1, 2'b10, 16'h6001, 1, 1, 1, 0, 0, 2'b00, 16'h0, 4, 2));
      vecs.push_back(mkv(1, 2'b01, 16'h7000, 0, 0, 1, 0, 0, 2'b00, 16'h0, 4, 2));
      vecs.push_back(mkv(1, 2'b11, 16'h7001, 0, 0, 1, 0, 0, 2'b00, 16'h0, 4, 2));
      vecs.push_back(mkv(1, 2'b10, 16'h7002, 1, 1, 1, 0, 0, 2'b00, 16'h0, 5, 2));
      vecs.push_back(mkv(0, 2'b00, 16'h0,    0, 0, 1, 0, 0, 2'b00, 16'h0, 5, 2));
      vecs.push_back(mkv(0, 2'b00, 16'h0,    0, 0, 1, 0, 0, 2'b00, 16'h0, 5, 2));
      vecs.push_back(mkv(0, 2'b00, 16'h0,    0, 0, 0, 0, 0, 2'b00, 16'h0, 5, 2));
      vecs.push_back(mkv(0, 2'b00, 16'h0,    0, 0, 1, 0, 0, 2'b00, 16'h0, 5, 2));
      vecs.push_back(mkv(0, 2'b00, 16'h0,    0, 0, 1, 1, 0, 2'b01, 16'h6000, 5, 2));
      vecs.push_back(mkv(0, 2'b00, 16'h0,    0, 0, 0, 1, 1, 2'b10, 16'h6001, 5, 2));
      vecs.push_back(mkv(0, 2'b00, 16'h0,    0, 0, 0, 0, 0, 2'b00, 16'h0, 5, 2));
      vecs.push_back(mkv(0, 2'b00, 16'h0,    0, 0, 0, 0, 0, 2'b00, 16'h0, 5, 2));
      vecs.push_back(mkv(0, 2'b00, 16'h0,    0, 0, 0, 1, 0, 2'b01, 16'h7000, 5, 2));

      // reset state
      @(posedge clk); #1;
      chk("reset out_data_wr", out_data_wr, 1'b0);
      chk("reset out_valid_wr", out_valid_wr, 1'b0);
      chk("reset out_valid", out_valid, 1'b0);
      chk("reset out_data", out_data, '0);
      chk("reset out_alf", out_alf, 1'b0);
      chk_stats("reset", 0, 0);
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;

      foreach (vecs[i]) begin
         in_alf = vecs[i].alf;
         cyc(vecs[i].d_wr, vecs[i].d_typ, vecs[i].d_tag, vecs[i].v_wr, vecs[i].vld);
         chk($sformatf("v%0d out_data_wr", i), out_data_wr, vecs[i].e_wr);
         chk($sformatf("v%0d out_valid_wr", i), out_valid_wr, vecs[i].e_vw);
         chk($sformatf("v%0d out_valid", i), out_valid, vecs[i].e_vw);
         if (vecs[i].e_wr)
            chk($sformatf("v%0d out_data", i), out_data, word(vecs[i].e_typ, vecs[i].e_tag));
         chk($sformatf("v%0d out_alf", i), out_alf, 1'b0);
         chk_stats($sformatf("v%0d", i), vecs[i].e_commit, vecs[i].e_drop);
      end

      // reset in the middle of the second packet
      #1 rst = 1'b1;
      #1;
      chk("midrst out_data_wr", out_data_wr, 1'b0);
      chk("midrst out_valid_wr", out_valid_wr, 1'b0);
      chk("midrst out_data", out_data, '0);
      chk("midrst out_alf", out_alf, 1'b0);
      chk_stats("midrst", 0, 0);
      #3 rst = 1'b0;
      spur = 0;
      for (int k = 0; k < 8; k++) begin
         cyc(1'b0, 2'b00, 16'h0, 1'b0, 1'b0);
         if (out_data_wr) spur++;
      end
      chk("after reset no output", spur, 0);

      // almost-full boundary: hold downstream off, fill the buffer
      in_alf = 1'b1;
      cyc(1'b1, 2'b01, 16'd0, 1'b0, 1'b0);
      for (int i = 1; i < 224; i++) cyc(1'b1, 2'b11, 16'(i), 1'b0, 1'b0);
      cyc(1'b0, 2'b00, 16'h0, 1'b0, 1'b0);
      chk("alf at 224 used", out_alf, 1'b0);
      cyc(1'b1, 2'b11, 16'd224, 1'b0, 1'b0);
      chk("alf lag", out_alf, 1'b0);
      cyc(1'b0, 2'b00, 16'h0, 1'b0, 1'b0);
      chk("alf at 225 used", out_alf, 1'b1);
      cyc(1'b1, 2'b10, 16'd225, 1'b1, 1'b1);
      chk_stats("fill commit", 1, 0);
      in_alf = 1'b0;
      cnt = 0; alf_cnt = -1; fell = 1'b0;
      for (int k = 0; k < 300 && cnt < 226; k++) begin
         cyc(1'b0, 2'b00, 16'h0, 1'b0, 1'b0);
         if (out_data_wr) begin
            et = (cnt == 0) ? 2'b01 : ((cnt == 225) ? 2'b10 : 2'b11);
            chk($sformatf("fill word%0d", cnt), out_data, word(et, 16'(cnt)));
            chk($sformatf("fill word%0d valid_wr", cnt), out_valid_wr, (cnt == 225));
            cnt++;
         end
         if (!out_alf && !fell) begin
            fell = 1'b1;
            alf_cnt = cnt;
         end
      end
      chk("fill word count", cnt, 226);
      chk("alf release point", alf_cnt, 2);

      // 300-word packet overflows the 256-word buffer and is rolled back
      spur = 0; alf_seen = 1'b0;
      cyc(1'b1, 2'b01, 16'd0, 1'b0, 1'b0);
      for (int i = 1; i < 299; i++) begin
         cyc(1'b1, 2'b11, 16'(i), 1'b0, 1'b0);
         if (out_data_wr) spur++;
         if (out_alf) alf_seen = 1'b1;
      end
      cyc(1'b1, 2'b10, 16'd299, 1'b1, 1'b1);
      chk("ovf alf at verdict", out_alf, 1'b1);
      chk("ovf alf seen", alf_seen, 1'b1);
      cyc(1'b0, 2'b00, 16'h0, 1'b0, 1'b0);
      chk("ovf alf after rollback", out_alf, 1'b0);
      for (int k = 0; k < 8; k++) begin
         cyc(1'b0, 2'b00, 16'h0, 1'b0, 1'b0);
         if (out_data_wr) spur++;
      end
      chk("ovf no output", spur, 0);
      chk_stats("ovf drop", 1, 1);

      // buffer is back to its committed state: a short packet goes through intact
      cyc(1'b1, 2'b01, 16'h5500, 1'b0, 1'b0);
      cyc(1'b1, 2'b10, 16'h5501, 1'b1, 1'b1);
      expect_pkt("post-ovf pkt", 2, 16'h5500);
      chk_stats("final", 2, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
